// File: rtl/spi_rx_deser.sv
// Receive deserialiser: packs 1/2/4-lane PHY samples into DW-bit words and
// emits them as a framed beat stream with sof/eof/partial/abort flags.
module spi_rx_deser #(
    parameter int DW        = 8,
    parameter int LANES     = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             finish,
    input  logic [LANES-1:0] rx_data,
    input  logic             rx_valid,
    output logic [DW-1:0]    stream_data,
    output logic             stream_vld,
    output logic             stream_sof,
    output logic             stream_eof,
    output logic             stream_partial,
    output logic             stream_abort,
    output logic [15:0]      frame_words
);

    localparam int SPW = DW / LANES;
    localparam int CW  = $clog2(SPW + 1);
    localparam logic [CW-1:0] SPW_C  = CW'(SPW);
    localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0] ZERO_C = CW'(1'b0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] sh, input logic [LANES-1:0] d);
        logic [DW-1:0] res;
        if (LSB_FIRST != 0) begin
            res = (sh >> LANES) | (DW'(d) << (DW - LANES));
        end else begin
            res = (sh << LANES) | DW'(d);
        end
        return res;
    endfunction

    // Pushes the n received samples to the word's leading edge, zero-filling the rest.
    function automatic logic [DW-1:0] align_partial(input logic [DW-1:0] sh, input logic [CW-1:0] n);
        logic [DW-1:0] res;
        int            pad;
        pad = (SPW - int'(n)) * LANES;
        if (LSB_FIRST != 0) begin
            res = sh >> pad;
        end else begin
            res = sh << pad;
        end
        return res;
    endfunction

    state_t          state_r, state_s;
    logic [DW-1:0]   sh_r, sh_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [DW-1:0]   pend_r, pend_s;
    logic            pend_full_r, pend_full_s;
    logic            first_r, first_s;
    logic            part_r, part_s;
    logic [DW-1:0]   data_r, data_s;
    logic            vld_r, vld_s;
    logic            sof_r, sof_s;
    logic            eof_r, eof_s;
    logic            partial_r, partial_s;
    logic            abort_r, abort_s;
    logic [15:0]     words_r, words_s;
    logic            take_s;
    logic            restart_s;

    // Next-state, datapath and beat generation.
    always_comb begin
        state_s     = state_r;
        sh_s        = sh_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        first_s     = first_r;
        part_s      = part_r;
        data_s      = data_r;
        vld_s       = 1'b0;
        sof_s       = 1'b0;
        eof_s       = 1'b0;
        partial_s   = 1'b0;
        abort_s     = 1'b0;
        words_s     = words_r;
        take_s      = 1'b0;
        restart_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    restart_s = 1'b1;
                    state_s   = RECV;
                end else begin
                    state_s   = IDLE;
                end
            end
            RECV: begin
                if (start) begin
                    restart_s = 1'b1;
                    abort_s   = 1'b1;
                end else begin
                    abort_s   = 1'b0;
                end
                take_s = rx_valid;
            end
            FLUSH: begin
                if (start) begin
                    restart_s = 1'b1;
                    abort_s   = 1'b1;
                    take_s    = rx_valid;
                    state_s   = RECV;
                end else begin
                    data_s    = pend_r;
                    vld_s     = 1'b1;
                    sof_s     = first_s;
                    eof_s     = 1'b1;
                    partial_s = part_r;
                    first_s   = 1'b0;
                    words_s   = (words_s == 16'hFFFF) ? words_s : words_s + 16'd1;
                    state_s   = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (restart_s) begin
            cnt_s       = ZERO_C;
            pend_full_s = 1'b0;
            first_s     = 1'b1;
            part_s      = 1'b0;
            words_s     = 16'd0;
        end else begin
            cnt_s       = cnt_s;
        end

        if (take_s) begin
            sh_s  = shift_in(sh_s, rx_data);
            cnt_s = cnt_s + ONE_C;
            if (cnt_s == SPW_C) begin
                cnt_s = ZERO_C;
                if (pend_full_s) begin
                    data_s  = pend_s;
                    vld_s   = 1'b1;
                    sof_s   = first_s;
                    first_s = 1'b0;
                    words_s = (words_s == 16'hFFFF) ? words_s : words_s + 16'd1;
                end else begin
                    vld_s   = vld_s;
                end
                pend_s      = sh_s;
                pend_full_s = 1'b1;
            end else begin
                cnt_s = cnt_s;
            end
        end else begin
            sh_s = sh_s;
        end

        // A full word completing alongside finish already used this cycle's beat; FLUSH sends it.
        if ((state_r == RECV) && !start && finish) begin
            if (cnt_s == ZERO_C) begin
                if (pend_full_s && vld_s) begin
                    part_s      = 1'b0;
                    pend_full_s = 1'b0;
                    state_s     = FLUSH;
                end else if (pend_full_s) begin
                    data_s      = pend_s;
                    vld_s       = 1'b1;
                    sof_s       = first_s;
                    eof_s       = 1'b1;
                    first_s     = 1'b0;
                    words_s     = (words_s == 16'hFFFF) ? words_s : words_s + 16'd1;
                    pend_full_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s     = IDLE;
                end
            end else begin
                if (pend_full_s) begin
                    data_s  = pend_s;
                    vld_s   = 1'b1;
                    sof_s   = first_s;
                    first_s = 1'b0;
                    words_s = (words_s == 16'hFFFF) ? words_s : words_s + 16'd1;
                end else begin
                    vld_s   = vld_s;
                end
                pend_s      = align_partial(sh_s, cnt_s);
                pend_full_s = 1'b0;
                part_s      = 1'b1;
                state_s     = FLUSH;
            end
        end else begin
            state_s = state_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sh_r        <= {DW{1'b0}};
            cnt_r       <= ZERO_C;
            pend_r      <= {DW{1'b0}};
            pend_full_r <= 1'b0;
            first_r     <= 1'b0;
            part_r      <= 1'b0;
            data_r      <= {DW{1'b0}};
            vld_r       <= 1'b0;
            sof_r       <= 1'b0;
            eof_r       <= 1'b0;
            partial_r   <= 1'b0;
            abort_r     <= 1'b0;
            words_r     <= 16'd0;
        end else begin
            state_r     <= state_s;
            sh_r        <= sh_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
            first_r     <= first_s;
            part_r      <= part_s;
            data_r      <= data_s;
            vld_r       <= vld_s;
            sof_r       <= sof_s;
            eof_r       <= eof_s;
            partial_r   <= partial_s;
            abort_r     <= abort_s;
            words_r     <= words_s;
        end
    end

    assign stream_data    = data_r;
    assign stream_vld     = vld_r;
    assign stream_sof     = sof_r;
    assign stream_eof     = eof_r;
    assign stream_partial = partial_r;
    assign stream_abort   = abort_r;
    assign frame_words    = words_r;

endmodule
